// File: rtl/cp0_pkg.sv
// cp0_pkg: shared constants and helpers for the coprocessor-0 register file.
//   Register numbers, exception codes, Status/Cause bit positions and a
//   helper that packs the architectural Cause word.
package cp0_pkg;
    localparam logic [4:0] CP0_COUNT   = 5'd9;
    localparam logic [4:0] CP0_COMPARE = 5'd11;
    localparam logic [4:0] CP0_STATUS  = 5'd12;
    localparam logic [4:0] CP0_CAUSE   = 5'd13;
    localparam logic [4:0] CP0_EPC     = 5'd14;

    localparam logic [4:0] EXC_OV = 5'd12;
    localparam logic [4:0] EXC_RI = 5'd10;

    localparam int ST_IE  = 0;
    localparam int ST_EXL = 1;
    localparam int CA_IP7 = 15;

    // Cause layout: IP7 at bit 15, ExcCode in [6:2], everything else zero.
    function automatic logic [31:0] cause_word(input logic ip7, input logic [4:0] exc);
        logic [31:0] w;
        w = {25'b0, exc, 2'b0};
        w[CA_IP7] = ip7;
        return w;
    endfunction
endpackage

// File: rtl/cp0_regs_timer.sv
// cp0_timer: Count/Compare timer with sticky match flag IP7.
//   clock, rst        : clock, asynchronous active-high reset
//   i_wr_count        : mtc0 write to Count (overrides the increment)
//   i_wr_compare      : mtc0 write to Compare (also clears IP7)
//   i_wdata           : mtc0 data
//   o_count/o_compare : current Count and Compare
//   o_ip7             : sticky timer-pending flag
module cp0_timer
    import cp0_pkg::*;
#(
    parameter logic [31:0] COUNT_RESET = 32'h0
) (
    input  logic        clock,
    input  logic        rst,
    input  logic        i_wr_count,
    input  logic        i_wr_compare,
    input  logic [31:0] i_wdata,
    output logic [31:0] o_count,
    output logic [31:0] o_compare,
    output logic        o_ip7
);
    logic [31:0] r_count;
    logic [31:0] r_compare;
    logic        r_ip7;
    logic        w_match;

    // Compare == 0 means the timer is disarmed.
    assign w_match = (r_count == r_compare) && (r_compare != 32'h0);

    always_ff @(posedge clock or posedge rst) begin
        if (rst) begin
            r_count   <= COUNT_RESET;
            r_compare <= 32'h0;
            r_ip7     <= 1'b0;
        end else begin
            r_count <= i_wr_count ? i_wdata : r_count + 32'd1;
            if (i_wr_compare)
                r_compare <= i_wdata;
            // A Compare write clears IP7 even if the old Compare matches this cycle.
            r_ip7 <= i_wr_compare ? 1'b0 : (r_ip7 | w_match);
        end
    end

    assign o_count   = r_count;
    assign o_compare = r_compare;
    assign o_ip7     = r_ip7;
endmodule

// File: rtl/cp0_regs.sv
// cp0_regs: coprocessor-0 register file (Status, Cause, EPC, Count/Compare timer).
//   clock, rst                 : clock, asynchronous active-high reset
//   sig_CauseWrite/IntCause    : exception capture (ExcCode + EXL)
//   sig_EPCWrite, pc_Current   : EPC capture
//   cp0_Addr/Write/WriteData   : mtc0 write port and mfc0 read select
//   cp0_ReadData               : combinational mfc0 read data
//   epc_Out, exc_Vector        : current EPC, constant handler address
//   timer_Irq                  : registered IP7 & IE & ~EXL
module cp0_regs
    import cp0_pkg::*;
#(
    parameter logic [31:0] EXC_VECTOR  = 32'h0000_0180,
    parameter logic [31:0] COUNT_RESET = 32'h0
) (
    input  logic        clock,
    input  logic        rst,
    input  logic        sig_CauseWrite,
    input  logic        sig_IntCause,
    input  logic        sig_EPCWrite,
    input  logic [31:0] pc_Current,
    input  logic [4:0]  cp0_Addr,
    input  logic        cp0_Write,
    input  logic [31:0] cp0_WriteData,
    output logic [31:0] cp0_ReadData,
    output logic [31:0] epc_Out,
    output logic [31:0] exc_Vector,
    output logic        timer_Irq
);
    logic        r_ie;
    logic        r_exl;
    logic [4:0]  r_exc;
    logic [31:0] r_epc;
    logic        r_irq;
    logic        w_wr_count;
    logic        w_wr_compare;
    logic        w_wr_status;
    logic        w_wr_cause;
    logic        w_wr_epc;
    logic [31:0] w_count;
    logic [31:0] w_compare;
    logic        w_ip7;

    assign w_wr_count   = cp0_Write && (cp0_Addr == CP0_COUNT);
    assign w_wr_compare = cp0_Write && (cp0_Addr == CP0_COMPARE);
    assign w_wr_status  = cp0_Write && (cp0_Addr == CP0_STATUS);
    assign w_wr_cause   = cp0_Write && (cp0_Addr == CP0_CAUSE);
    assign w_wr_epc     = cp0_Write && (cp0_Addr == CP0_EPC);

    cp0_timer #(.COUNT_RESET(COUNT_RESET)) u_timer (
        .clock       (clock),
        .rst         (rst),
        .i_wr_count  (w_wr_count),
        .i_wr_compare(w_wr_compare),
        .i_wdata     (cp0_WriteData),
        .o_count     (w_count),
        .o_compare   (w_compare),
        .o_ip7       (w_ip7)
    );

    // Hardware capture takes priority over a same-cycle mtc0 for ExcCode, EXL and EPC.
    always_ff @(posedge clock or posedge rst) begin
        if (rst) begin
            r_ie  <= 1'b0;
            r_exl <= 1'b0;
            r_exc <= 5'd0;
            r_epc <= 32'h0;
            r_irq <= 1'b0;
        end else begin
            r_ie  <= w_wr_status ? cp0_WriteData[ST_IE] : r_ie;
            r_exl <= sig_CauseWrite ? 1'b1 : (w_wr_status ? cp0_WriteData[ST_EXL] : r_exl);
            r_exc <= sig_CauseWrite ? (sig_IntCause ? EXC_RI : EXC_OV) :
                     (w_wr_cause ? cp0_WriteData[6:2] : r_exc);
            r_epc <= sig_EPCWrite ? pc_Current : (w_wr_epc ? cp0_WriteData : r_epc);
            r_irq <= w_ip7 & r_ie & ~r_exl;
        end
    end

    always_comb begin
        cp0_ReadData = 32'h0;
        case (cp0_Addr)
            CP0_COUNT:   cp0_ReadData = w_count;
            CP0_COMPARE: cp0_ReadData = w_compare;
            CP0_STATUS:  cp0_ReadData = {30'b0, r_exl, r_ie};
            CP0_CAUSE:   cp0_ReadData = cause_word(w_ip7, r_exc);
            CP0_EPC:     cp0_ReadData = r_epc;
            default:     cp0_ReadData = 32'h0;
        endcase
    end

    assign epc_Out    = r_epc;
    assign exc_Vector = EXC_VECTOR;
    assign timer_Irq  = r_irq;
endmodule

// File: tb/tb_cp0_regs.sv
// tb_cp0_regs: table-driven bench for cp0_regs plus timer, wrap and reset sequences.
module tb_cp0_regs;
    import cp0_pkg::*;

    localparam logic [31:0] CR = 32'h0000_0010;
    localparam logic [31:0] EV = 32'h0000_0180;

    logic        clock = 1'b0;
    logic        rst = 1'b1;
    logic        sig_CauseWrite = 1'b0;
    logic        sig_IntCause = 1'b0;
    logic        sig_EPCWrite = 1'b0;
    logic [31:0] pc_Current = 32'h0;
    logic [4:0]  cp0_Addr = 5'd0;
    logic        cp0_Write = 1'b0;
    logic [31:0] cp0_WriteData = 32'h0;
    logic [31:0] cp0_ReadData;
    logic [31:0] epc_Out;
    logic [31:0] exc_Vector;
    logic        timer_Irq;

    int n_vec = 0;
    int n_bad = 0;

    cp0_regs #(.EXC_VECTOR(EV), .COUNT_RESET(CR)) dut (
        .clock        (clock),
        .rst          (rst),
        .sig_CauseWrite(sig_CauseWrite),
        .sig_IntCause (sig_IntCause),
        .sig_EPCWrite (sig_EPCWrite),
        .pc_Current   (pc_Current),
        .cp0_Addr     (cp0_Addr),
        .cp0_Write    (cp0_Write),
        .cp0_WriteData(cp0_WriteData),
        .cp0_ReadData (cp0_ReadData),
        .epc_Out      (epc_Out),
        .exc_Vector   (exc_Vector),
        .timer_Irq    (timer_Irq)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic        w;
        logic [4:0]  wa;
        logic [31:0] wd;
        logic        cw;
        logic        ic;
        logic        ew;
        logic [31:0] pc;
        logic [4:0]  ra;
        logic [31:0] exp;
    } vec_t;

    vec_t tbl[19];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic rd(input string name, input logic [4:0] a, input logic [31:0] exp);
        cp0_Addr = a;
        #1;
        chk(name, cp0_ReadData, exp);
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    task automatic mtc0(input logic [4:0] a, input logic [31:0] d);
        cp0_Write = 1'b1;
        cp0_Addr = a;
        cp0_WriteData = d;
        @(posedge clock);
        #1;
        cp0_Write = 1'b0;
    endtask

    initial begin
        tbl[0]  = '{1'b1, CP0_STATUS,  32'hFFFF_FFFF, 1'b0, 1'b0, 1'b0, 32'h0,  CP0_STATUS,  32'h3};
        tbl[1]  = '{1'b1, CP0_STATUS,  32'h0,         1'b0, 1'b0, 1'b0, 32'h0,  CP0_STATUS,  32'h0};
        tbl[2]  = '{1'b1, CP0_STATUS,  32'h1,         1'b0, 1'b0, 1'b0, 32'h0,  CP0_STATUS,  32'h1};
        tbl[3]  = '{1'b0, 5'd0,        32'h0,         1'b1, 1'b0, 1'b1, 32'h40, CP0_CAUSE,   32'h30};
        tbl[4]  = '{1'b0, 5'd0,        32'h0,         1'b0, 1'b0, 1'b0, 32'h0,  CP0_STATUS,  32'h3};
        tbl[5]  = '{1'b0, 5'd0,        32'h0,         1'b0, 1'b0, 1'b0, 32'h0,  CP0_EPC,     32'h40};
        tbl[6]  = '{1'b1, CP0_CAUSE,   32'h7C,        1'b1, 1'b1, 1'b0, 32'h0,  CP0_CAUSE,   32'h28};
        tbl[7]  = '{1'b1, CP0_CAUSE,   32'hFFFF_FFFF, 1'b0, 1'b0, 1'b0, 32'h0,  CP0_CAUSE,   32'h7C};
        tbl[8]  = '{1'b1, CP0_STATUS,  32'h0,         1'b1, 1'b0, 1'b0, 32'h0,  CP0_STATUS,  32'h2};
        tbl[9]  = '{1'b0, 5'd0,        32'h0,         1'b0, 1'b0, 1'b0, 32'h0,  CP0_CAUSE,   32'h30};
        tbl[10] = '{1'b1, CP0_EPC,     32'h1234,      1'b0, 1'b0, 1'b1, 32'h88, CP0_EPC,     32'h88};
        tbl[11] = '{1'b1, CP0_EPC,     32'hABCD,      1'b0, 1'b0, 1'b0, 32'h0,  CP0_EPC,     32'hABCD};
        tbl[12] = '{1'b1, 5'd3,        32'hDEAD,      1'b0, 1'b0, 1'b0, 32'h0,  5'd3,        32'h0};
        tbl[13] = '{1'b0, 5'd0,        32'h0,         1'b0, 1'b0, 1'b0, 32'h0,  CP0_EPC,     32'hABCD};
        tbl[14] = '{1'b0, 5'd0,        32'h0,         1'b0, 1'b0, 1'b0, 32'h0,  CP0_STATUS,  32'h2};
        tbl[15] = '{1'b0, 5'd0,        32'h0,         1'b0, 1'b0, 1'b0, 32'h0,  CP0_CAUSE,   32'h30};
        tbl[16] = '{1'b0, 5'd0,        32'h0,         1'b0, 1'b0, 1'b0, 32'h0,  5'd31,       32'h0};
        tbl[17] = '{1'b1, CP0_COMPARE, 32'h55,        1'b0, 1'b0, 1'b0, 32'h0,  CP0_COMPARE, 32'h55};
        tbl[18] = '{1'b1, CP0_COMPARE, 32'h0,         1'b0, 1'b0, 1'b0, 32'h0,  CP0_COMPARE, 32'h0};

        #2;
        rd("rst_status", CP0_STATUS, 32'h0);
        rd("rst_cause", CP0_CAUSE, 32'h0);
        rd("rst_epc", CP0_EPC, 32'h0);
        rd("rst_count", CP0_COUNT, CR);
        chk("rst_irq", {31'b0, timer_Irq}, 32'h0);
        chk("exc_vector", exc_Vector, EV);
        @(negedge clock);
        rst = 1'b0;
        idle(1);
        rd("count_first", CP0_COUNT, CR + 32'd1);

        for (int i = 0; i < 19; i++) begin
            cp0_Write = tbl[i].w;
            cp0_Addr = tbl[i].wa;
            cp0_WriteData = tbl[i].wd;
            sig_CauseWrite = tbl[i].cw;
            sig_IntCause = tbl[i].ic;
            sig_EPCWrite = tbl[i].ew;
            pc_Current = tbl[i].pc;
            @(posedge clock);
            #1;
            cp0_Write = 1'b0;
            sig_CauseWrite = 1'b0;
            sig_EPCWrite = 1'b0;
            rd($sformatf("vec%0d", i), tbl[i].ra, tbl[i].exp);
        end
        chk("epc_out", epc_Out, 32'hABCD);

        // Timer: match at Count == 5, IP7 one edge later, IRQ one more edge.
        mtc0(CP0_STATUS, 32'h1);
        mtc0(CP0_COMPARE, 32'h5);
        mtc0(CP0_COUNT, 32'h0);
        rd("tmr_count0", CP0_COUNT, 32'h0);
        idle(5);
        rd("tmr_count5", CP0_COUNT, 32'h5);
        rd("tmr_ip7_pre", CP0_CAUSE, 32'h30);
        idle(1);
        rd("tmr_ip7_set", CP0_CAUSE, 32'h8030);
        chk("tmr_irq_lag", {31'b0, timer_Irq}, 32'h0);
        idle(1);
        chk("tmr_irq_up", {31'b0, timer_Irq}, 32'h1);
        sig_CauseWrite = 1'b1;
        sig_IntCause = 1'b0;
        @(posedge clock);
        #1;
        sig_CauseWrite = 1'b0;
        rd("tmr_exl", CP0_STATUS, 32'h3);
        idle(1);
        chk("tmr_irq_exl", {31'b0, timer_Irq}, 32'h0);
        mtc0(CP0_STATUS, 32'h1);
        idle(1);
        chk("tmr_irq_again", {31'b0, timer_Irq}, 32'h1);
        mtc0(CP0_COMPARE, 32'h100);
        rd("tmr_ip7_clr", CP0_CAUSE, 32'h30);
        idle(1);
        chk("tmr_irq_clr", {31'b0, timer_Irq}, 32'h0);

        // Compare write on the very edge where the old Compare matches: clear wins.
        mtc0(CP0_COUNT, 32'h0);
        mtc0(CP0_COMPARE, 32'h3);
        idle(2);
        rd("sim_count3", CP0_COUNT, 32'h3);
        mtc0(CP0_COMPARE, 32'h200);
        rd("sim_ip7", CP0_CAUSE, 32'h30);
        rd("sim_compare", CP0_COMPARE, 32'h200);

        // Wrap with timer disarmed.
        mtc0(CP0_COMPARE, 32'h0);
        mtc0(CP0_COUNT, 32'hFFFF_FFFE);
        rd("wrap_fe", CP0_COUNT, 32'hFFFF_FFFE);
        idle(1);
        rd("wrap_ff", CP0_COUNT, 32'hFFFF_FFFF);
        idle(1);
        rd("wrap_0", CP0_COUNT, 32'h0);
        idle(1);
        rd("wrap_1", CP0_COUNT, 32'h1);
        rd("wrap_ip7", CP0_CAUSE, 32'h30);

        // Mid-run async reset with the IRQ asserted and Count at 0x1234.
        mtc0(CP0_COMPARE, 32'h1232);
        mtc0(CP0_COUNT, 32'h1230);
        idle(4);
        rd("pre_rst_count", CP0_COUNT, 32'h1234);
        chk("pre_rst_irq", {31'b0, timer_Irq}, 32'h1);
        #2;
        rst = 1'b1;
        #1;
        chk("arst_irq", {31'b0, timer_Irq}, 32'h0);
        chk("arst_epc_out", epc_Out, 32'h0);
        rd("arst_count", CP0_COUNT, CR);
        rd("arst_compare", CP0_COMPARE, 32'h0);
        rd("arst_status", CP0_STATUS, 32'h0);
        rd("arst_cause", CP0_CAUSE, 32'h0);
        rd("arst_epc", CP0_EPC, 32'h0);
        @(negedge clock);
        rst = 1'b0;
        idle(1);
        rd("post_rst_count", CP0_COUNT, CR + 32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
